powlib_busburst: RTL

Bus write-burst generator that sits directly upstream of a powlib_buscross write port and drives its wrdata/wraddr/wrvld/wrrdy interface. It accepts a single command (base address, beat count, data seed) and emits that many write beats. Addresses are consecutive with a fixed stride; data is an incrementing pattern. It is used by bench traffic generators and by simple fill/DMA engines feeding the crossbar.

---
 rtl/powlib_busburst_pkg.sv | 13 +
 rtl/powlib_busburst_beatreg.sv | 46 ++++
 rtl/powlib_busburst.sv | 123 ++++++++++++
 3 files changed

// File: rtl/powlib_busburst_pkg.sv
// Shared types for the burst write generator.
package powlib_busburst_pkg;

  localparam int unsigned ST_W = 2;

  // Burst sequencer states; encodings match the powlib header values.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } burst_state_e;

endpackage : powlib_busburst_pkg

// File: rtl/powlib_busburst_beatreg.sv
// Beat address/data/remaining-count register: loads a command, steps per beat.
module powlib_busburst_beatreg #(
  parameter int unsigned B_AW  = 16,
  parameter int unsigned B_DW  = 32,
  parameter int unsigned CW    = 8,
  parameter int unsigned ASTEP = 1,
  parameter int unsigned DSTEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [B_AW-1:0] ld_addr_i,
  input  logic [B_DW-1:0] ld_data_i,
  input  logic [CW-1:0]   ld_cnt_i,
  output logic [B_AW-1:0] addr_o,
  output logic [B_DW-1:0] data_o,
  output logic [CW-1:0]   remaining_o
);

  logic [B_AW-1:0] addr_q;
  logic [B_DW-1:0] data_q;
  logic [CW-1:0]   remaining_q;

  // Load on command accept, advance on every non-final transfer; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
    end else if (load_i) begin
      addr_q      <= ld_addr_i;
      data_q      <= ld_data_i;
      remaining_q <= ld_cnt_i;
    end else if (step_i) begin
      addr_q      <= addr_q + B_AW'(ASTEP);
      data_q      <= data_q + B_DW'(DSTEP);
      remaining_q <= remaining_q - CW'(1);
    end
  end

  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign remaining_o = remaining_q;

endmodule : powlib_busburst_beatreg

// File: rtl/powlib_busburst.sv
// Write-burst generator: one command in, cmdcnt consecutive write beats out.
module powlib_busburst
  import powlib_busburst_pkg::*;
#(
  parameter int unsigned B_AW  = 16,
  parameter int unsigned B_DW  = 32,
  parameter int unsigned CW    = 8,
  parameter int unsigned ASTEP = 1,
  parameter int unsigned DSTEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] cmdaddr,
  input  logic [CW-1:0]   cmdcnt,
  input  logic [B_DW-1:0] cmdseed,
  input  logic            cmdvld,
  output logic            cmdrdy,
  output logic [B_DW-1:0] wrdata,
  output logic [B_AW-1:0] wraddr,
  output logic            wrvld,
  input  logic            wrrdy,
  output logic            busy,
  output logic            done
);

  burst_state_e state_q;
  logic         cmdrdy_q;
  logic         wrvld_q;
  logic         busy_q;
  logic         done_q;
  logic [CW-1:0] remaining;

  logic accept_c;
  logic xfer_c;
  logic last_c;
  logic load_c;
  logic step_c;

  // Handshake qualifiers shared by the sequencer and the beat register.
  assign accept_c = (state_q == ST_IDLE) && cmdvld && cmdrdy_q;
  assign xfer_c   = wrvld_q && wrrdy;
  assign last_c   = (remaining == CW'(1));
  assign load_c   = accept_c && (cmdcnt != '0);
  assign step_c   = xfer_c && !last_c;

  powlib_busburst_beatreg #(
    .B_AW  (B_AW),
    .B_DW  (B_DW),
    .CW    (CW),
    .ASTEP (ASTEP),
    .DSTEP (DSTEP)
  ) u_beatreg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .step_i      (step_c),
    .ld_addr_i   (cmdaddr),
    .ld_data_i   (cmdseed),
    .ld_cnt_i    (cmdcnt),
    .addr_o      (wraddr),
    .data_o      (wrdata),
    .remaining_o (remaining)
  );

  // Burst sequencer with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmdrdy_q <= 1'b0;
      wrvld_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept_c) begin
            cmdrdy_q <= 1'b0;
            busy_q   <= 1'b1;
            if (cmdcnt != '0) begin
              state_q <= ST_BURST;
              wrvld_q <= 1'b1;
            end else begin
              // Empty burst goes straight to completion.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cmdrdy_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        ST_BURST: begin
          // wrvld only drops on the final transfer.
          if (xfer_c && last_c) begin
            state_q <= ST_DONE;
            wrvld_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          cmdrdy_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          cmdrdy_q <= 1'b0;
          wrvld_q  <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmdrdy = cmdrdy_q;
  assign wrvld  = wrvld_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule : powlib_busburst
